alu_seq_ctrl: RTL and testbench

Sequencing controller that sits on the operand/result side of the 16-bit combinational ALU (op 00 add, 01 sub, 10 AND, 11 OR).
- Owns an 8-entry register file and accepts register-to-register instructions over a valid/ready handshake.
- Drives the ALU's op/i0/i1 inputs, captures o/cout, writes the result back and updates carry/zero flags.
- Provides an external load port and a debug read port so a bench or loader can initialise and inspect registers.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_ctrl_regfile.sv | 37 +++
 rtl/alu_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencing controller.
package alu_seq_pkg;

  localparam int DATA_W_DFLT = 16;
  localparam int NREGS_DFLT  = 8;
  localparam int AW_DFLT     = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } seq_state_t;

  // Only the arithmetic ops update the carry flag.
  function automatic logic op_sets_carry(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_regfile.sv
// Register file: one synchronous write port, three asynchronous read ports.
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int NREGS  = NREGS_DFLT,
  parameter int AW     = AW_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  input  logic [AW-1:0]     raddr_d,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_d
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage with asynchronous clear; a single writer per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller around an external 16-bit combinational ALU.
//
// state | meaning
// IDLE  | waiting for an instruction handshake; external loads honoured here
// READ  | register operands and op onto the ALU inputs
// EXEC  | ALU inputs held a full cycle; result and carry captured at the end
// WB    | result written to rd, flags updated, done pulses
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int NREGS  = NREGS_DFLT,
  parameter int AW     = AW_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [1:0]        ins_op,
  input  logic [AW-1:0]     ins_rd,
  input  logic [AW-1:0]     ins_rs1,
  input  logic [AW-1:0]     ins_rs2,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_cout,
  output logic              done,
  output logic              flag_c,
  output logic              flag_z
);

  seq_state_t state, state_nxt;

  logic [1:0]        op_q;
  logic [AW-1:0]     rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic              accept;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_a, rd_b;

  // Loads and instructions are mutually exclusive in IDLE: a load blocks the handshake.
  assign ins_ready = (state == ST_IDLE) & ~ld_en & rst_n;
  assign accept    = ins_valid & ins_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and done decode; every accepted instruction runs to completion.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: field latch, operand staging, result capture and flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= ins_op;
        rd_q  <= ins_rd;
        rs1_q <= ins_rs1;
        rs2_q <= ins_rs2;
      end
      if (state == ST_READ) begin
        alu_a  <= rd_a;
        alu_b  <= rd_b;
        alu_op <= op_q;
      end
      if (state == ST_EXEC) begin
        result_q <= alu_o;
        carry_q  <= alu_cout;
      end
      if (state == ST_WB) begin
        flag_z <= (result_q == '0);
        if (op_sets_carry(op_q)) flag_c <= carry_q;
      end
    end
  end

  // Write port shared by writeback and the external loader.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = result_q;
    end else if ((state == ST_IDLE) && ld_en) begin
      rf_we = 1'b1;
    end
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs1_q),
    .raddr_b (rs2_q),
    .raddr_d (dbg_addr),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .rdata_d (dbg_data)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a stand-in combinational ALU.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [1:0]  ins_op = '0;
  logic [2:0]  ins_rd = '0, ins_rs1 = '0, ins_rs2 = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_o;
  logic        alu_cout;
  logic        done, flag_c, flag_z;

  logic [2:0]  main_sel = '0;
  logic [2:0]  mon_sel = '0;
  logic        mon_owns = 1'b0;
  logic        mon_busy = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] res;
    logic        c;
    logic        z;
    int          acc_cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] m_regs [8];
  logic        m_c = 1'b0;
  logic        m_z = 1'b0;

  assign dbg_addr = mon_owns ? mon_sel : main_sel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external ripple ALU.
  always_comb begin
    logic [16:0] s;
    s = '0;
    case (alu_op)
      2'b00: s = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      2'b10: s = {1'b0, alu_a & alu_b};
      default: s = {1'b0, alu_a | alu_b};
    endcase
    alu_o    = s[15:0];
    alu_cout = s[16];
  end

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
    .ins_rd(ins_rd), .ins_rs1(ins_rs1), .ins_rs2(ins_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .done(done), .flag_c(flag_c), .flag_z(flag_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference semantics: two's-complement arithmetic, carry = bit 16 of the sum.
  task automatic model_exec(input logic [1:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2);
    logic [16:0] a, b, s;
    exp_t e;
    a = {1'b0, m_regs[rs1]};
    b = {1'b0, m_regs[rs2]};
    case (op)
      2'b00: begin s = a + b; m_c = s[16]; end
      2'b01: begin s = a + (17'h10000 - b); m_c = (m_regs[rs1] >= m_regs[rs2]); end
      2'b10: s = a & b;
      default: s = a | b;
    endcase
    m_regs[rd] = s[15:0];
    m_z = (s[15:0] == 16'h0000);
    e.rd = rd; e.res = s[15:0]; e.c = m_c; e.z = m_z; e.acc_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2);
    int tries = 0;
    bit ok = 1'b0;
    @(negedge clk);
    ins_valid = 1'b1; ins_op = op; ins_rd = rd; ins_rs1 = rs1; ins_rs2 = rs2;
    while (!ok && tries < 60) begin
      #1;
      if (ins_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
        tries++;
      end
    end
    ins_valid = 1'b0;
    if (ok) model_exec(op, rd, rs1, rs2);
    else chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int tries = 0;
    while ((exp_q.size() != 0 || mon_busy) && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    if (exp_q.size() != 0 || mon_busy) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [2:0] a, input logic [15:0] d);
    drain();
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    m_regs[a] = d;
    ld_en = 1'b0;
  endtask

  task automatic dump(input string tag);
    drain();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      main_sel = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {16'h0, dbg_data}, {16'h0, m_regs[i]});
    end
    chk({tag, "_flag_c"}, {31'h0, flag_c}, {31'h0, m_c});
    chk({tag, "_flag_z"}, {31'h0, flag_z}, {31'h0, m_z});
    chk({tag, "_ready"}, {31'h0, ins_ready}, 32'd1);
  endtask

  // Monitor: pops one expectation per done pulse and checks writeback and flags.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          chk("done_latency", 32'(cyc - e.acc_cyc), 32'd2);
          mon_sel = e.rd;
          mon_owns = 1'b1;
          #1;
          chk("old_value_in_wb", {31'h0, done}, 32'd1);
          @(posedge clk); #1;
          chk("wb_data", {16'h0, dbg_data}, {16'h0, e.res});
          chk("wb_flag_c", {31'h0, flag_c}, {31'h0, e.c});
          chk("wb_flag_z", {31'h0, flag_z}, {31'h0, e.z});
          chk("done_one_cycle", {31'h0, done}, 32'd0);
          mon_owns = 1'b0;
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {31'h0, ins_ready}, 32'd0);
    rst_n = 1'b1;
    dump("reset");

    do_load(3'd1, 16'd5); do_load(3'd2, 16'd3);
    issue(2'b01, 3'd3, 3'd1, 3'd2);
    issue(2'b01, 3'd4, 3'd2, 3'd1);
    do_load(3'd1, 16'hFFFF); do_load(3'd2, 16'h0001);
    issue(2'b00, 3'd0, 3'd1, 3'd2);
    do_load(3'd1, 16'hF0F0); do_load(3'd2, 16'h0FF0);
    issue(2'b10, 3'd5, 3'd1, 3'd2);
    issue(2'b11, 3'd6, 3'd1, 3'd2);
    do_load(3'd1, 16'h4000);
    issue(2'b00, 3'd1, 3'd1, 3'd1);
    issue(2'b00, 3'd2, 3'd1, 3'd1);
    dump("directed");
    chk("sub_result_r3", {16'h0, m_regs[3]}, 32'h0002);
    chk("hazard_r2", {16'h0, m_regs[2]}, 32'h0000);

    // Load and instruction offered together: load wins, instruction follows.
    drain();
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h1234;
    ins_valid = 1'b1; ins_op = 2'b00; ins_rd = 3'd7; ins_rs1 = 3'd6; ins_rs2 = 3'd6;
    #1;
    chk("collision_ready", {31'h0, ins_ready}, 32'd0);
    @(posedge clk); #1;
    m_regs[6] = 16'h1234;
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    chk("collision_ready_next", {31'h0, ins_ready}, 32'd1);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    model_exec(2'b00, 3'd7, 3'd6, 3'd6);

    // Load during EXEC is dropped.
    issue(2'b11, 3'd4, 3'd6, 3'd1);
    @(negedge clk);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'hABCD;
    @(negedge clk);
    ld_en = 1'b0;
    dump("ld_exec");

    // Reset asserted in EXEC aborts the instruction.
    issue(2'b00, 3'd3, 3'd6, 3'd6);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_c = 1'b0; m_z = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_low_in_reset", {31'h0, ins_ready}, 32'd0);
      chk("no_done_in_reset", {31'h0, done}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'h0, ins_ready}, 32'd1);
    repeat (4) @(negedge clk);
    dump("post_reset");

    // Randomised mix of loads and back-to-back instructions.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(3'($urandom_range(0, 7)), 16'($urandom));
      else
        issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    dump("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
